// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the 5-stage pipeline.
// Ports:
//   CLK, nRST (async, active-low)
//   ihit, dhit            : instruction / data memory hit
//   exmem_dREN/dWEN       : MEM-stage memory request
//   idex_dREN, idex_wsel  : EX-stage load and its destination
//   ifid_rs/rt/uses_rt    : ID-stage source registers
//   pc_redirect, halt_wb  : taken branch/jump in EX, halt at MEM/WB
//   pc_en, *_en, *_flush  : latch and PC controls (combinational)
//   halted                : sticky halt status
//   stall_cnt, flush_cnt  : saturating performance counters
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_wsel,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             pc_redirect,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic mem_req;
    logic mem_ok;
    logic lu_haz;
    logic fe_adv;
    logic be_adv;
    logic hold;
    logic do_redir;
    logic do_bub;
    logic do_norm;
    logic do_be;
    logic stall_inc;
    logic flush_inc;

    assign mem_req = exmem_dREN | exmem_dWEN;
    assign mem_ok  = !mem_req | dhit;

    // $0 is hardwired zero, so a load targeting it never hazards
    assign lu_haz = idex_dREN
                  & (idex_wsel != 5'd0)
                  & ((idex_wsel == ifid_rs)
                    | (ifid_uses_rt & (idex_wsel == ifid_rt)));

    assign fe_adv = ihit & mem_ok;
    assign be_adv = mem_ok & (ihit | dhit);

    // Halt (current or arriving) freezes everything
    assign hold = (state == HALT) | halt_wb;

    // Mutually exclusive action selects; redirect squashes the
    // hazarding instruction so it beats the load-use bubble
    assign do_redir = !hold & fe_adv & pc_redirect;
    assign do_bub   = !hold & fe_adv & !pc_redirect & lu_haz;
    assign do_norm  = !hold & fe_adv & !pc_redirect & !lu_haz;
    assign do_be    = !hold & !fe_adv & be_adv;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        unique case (1'b1)
            do_redir: begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            do_bub: begin
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
            do_norm: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
            do_be: begin
                // Bubble into EX/MEM so the held EX
                // instruction is not issued twice
                exmem_en    = 1'b1;
                exmem_flush = 1'b1;
                memwb_en    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RUN:     if (mem_req && !dhit) state_n = DWAIT;
            DWAIT:   if (dhit) state_n = RUN;
            HALT:    state_n = HALT;
            default: state_n = RUN;
        endcase
        if (halt_wb) state_n = HALT;
    end

    assign stall_inc = !hold & !pc_en;
    assign flush_inc = do_redir;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (halt_wb) halted <= 1'b1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl.
// Second instance with CNT_W=4 exercises counter saturation.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic        exmem_dREN, exmem_dWEN;
    logic        idex_dREN;
    logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
    logic        ifid_uses_rt, pc_redirect, halt_wb;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, halted;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4;
    logic        exmem_en4, exmem_flush4, memwb_en4, halted4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_cmp;
    int n_bad;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DWAIT = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb}
    localparam logic [7:0] O_NORM = 8'b1101_0101;
    localparam logic [7:0] O_BUB  = 8'b0001_1101;
    localparam logic [7:0] O_RED  = 8'b1111_1101;
    localparam logic [7:0] O_BE   = 8'b0000_0111;
    localparam logic [7:0] O_NONE = 8'b0000_0000;

    logic [7:0] outs;
    assign outs = {pc_en, ifid_en, ifid_flush, idex_en,
                   idex_flush, exmem_en, exmem_flush, memwb_en};

    always #5 CLK = ~CLK;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .pc_redirect(pc_redirect),
        .halt_wb(halt_wb), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en),
        .exmem_flush(exmem_flush), .memwb_en(memwb_en),
        .halted(halted), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .pc_redirect(pc_redirect),
        .halt_wb(halt_wb), .pc_en(pc_en4), .ifid_en(ifid_en4),
        .ifid_flush(ifid_flush4), .idex_en(idex_en4),
        .idex_flush(idex_flush4), .exmem_en(exmem_en4),
        .exmem_flush(exmem_flush4), .memwb_en(memwb_en4),
        .halted(halted4), .stall_cnt(stall_cnt4),
        .flush_cnt(flush_cnt4)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic idle();
        ihit         = 1'b1;
        dhit         = 1'b0;
        exmem_dREN   = 1'b0;
        exmem_dWEN   = 1'b0;
        idex_dREN    = 1'b0;
        idex_wsel    = 5'd0;
        ifid_rs      = 5'd0;
        ifid_rt      = 5'd0;
        ifid_uses_rt = 1'b0;
        pc_redirect  = 1'b0;
        halt_wb      = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST  = 1'b0;
        idle();
        #2;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);
        chk("rst_state", 32'(dut.state), 32'(S_RUN));
        @(negedge CLK);
        nRST = 1'b1;

        // Normal flow
        for (int i = 0; i < 5; i++) begin
            #1 chk("norm_outs", 32'(outs), 32'(O_NORM));
            @(negedge CLK);
        end
        chk("norm_stall", stall_cnt, 32'd0);
        chk("norm_flush", flush_cnt, 32'd0);

        // Load-use on rs
        idex_dREN = 1'b1;
        idex_wsel = 5'd5;
        ifid_rs   = 5'd5;
        #1 chk("lu_rs_outs", 32'(outs), 32'(O_BUB));
        @(negedge CLK);
        chk("lu_rs_stall", stall_cnt, 32'd1);

        // Destination $0: no hazard
        idex_wsel = 5'd0;
        ifid_rs   = 5'd0;
        #1 chk("lu_r0_outs", 32'(outs), 32'(O_NORM));
        @(negedge CLK);
        chk("lu_r0_stall", stall_cnt, 32'd1);

        // Load-use on rt
        idex_wsel    = 5'd7;
        ifid_rs      = 5'd3;
        ifid_rt      = 5'd7;
        ifid_uses_rt = 1'b1;
        #1 chk("lu_rt_outs", 32'(outs), 32'(O_BUB));
        @(negedge CLK);
        chk("lu_rt_stall", stall_cnt, 32'd2);

        // rt match but not used
        ifid_uses_rt = 1'b0;
        #1 chk("lu_rt_unused", 32'(outs), 32'(O_NORM));
        @(negedge CLK);
        chk("lu_rt_un_stall", stall_cnt, 32'd2);

        // Redirect with simultaneous hazard
        ifid_rs     = 5'd7;
        pc_redirect = 1'b1;
        #1 chk("redir_outs", 32'(outs), 32'(O_RED));
        @(negedge CLK);
        chk("redir_flush", flush_cnt, 32'd1);
        chk("redir_stall", stall_cnt, 32'd2);
        pc_redirect = 1'b0;
        idex_dREN   = 1'b0;

        // Store with ihit and dhit together
        exmem_dWEN = 1'b1;
        dhit       = 1'b1;
        #1 chk("both_hit_outs", 32'(outs), 32'(O_NORM));
        @(negedge CLK);
        chk("both_hit_state", 32'(dut.state), 32'(S_RUN));

        // Data miss, then back-end-only advance
        do_reset();
        exmem_dREN = 1'b1;
        dhit       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dwait_outs", 32'(outs), 32'(O_NONE));
            chk("dwait_state", 32'(dut.state),
                (i == 0) ? 32'(S_RUN) : 32'(S_DWAIT));
            @(negedge CLK);
        end
        dhit = 1'b1;
        ihit = 1'b0;
        #1 chk("be_outs", 32'(outs), 32'(O_BE));
        chk("be_state", 32'(dut.state), 32'(S_DWAIT));
        @(negedge CLK);
        chk("be_ret_state", 32'(dut.state), 32'(S_RUN));
        chk("be_stall", stall_cnt, 32'd4);

        // Halt
        exmem_dREN = 1'b0;
        dhit       = 1'b0;
        ihit       = 1'b1;
        halt_wb    = 1'b1;
        #1 chk("halt_outs", 32'(outs), 32'(O_NONE));
        @(negedge CLK);
        chk("halted", 32'(halted), 32'd1);
        chk("halt_state", 32'(dut.state), 32'(S_HALT));
        halt_wb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ihit        = i[0];
            dhit        = ~i[0];
            pc_redirect = i[1];
            #1 chk("halt_hold_outs", 32'(outs), 32'(O_NONE));
            @(negedge CLK);
            chk("halt_stall", stall_cnt, 32'd4);
            chk("halt_flush", flush_cnt, 32'd0);
            chk("halt_sticky", 32'(halted), 32'd1);
        end
        nRST = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_state", 32'(dut.state), 32'(S_RUN));
        chk("halt_rst_stall", stall_cnt, 32'd0);
        idle();
        @(negedge CLK);
        nRST = 1'b1;

        // Long stall: 4-bit counter saturates
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge CLK);
        chk("long_stall32", stall_cnt, 32'd20);
        chk("sat_stall4", 32'(stall_cnt4), 32'd15);
        @(negedge CLK);
        chk("sat_hold4", 32'(stall_cnt4), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
